// File: rtl/sort_pkg.sv
// Shared types and defaults for the bubble-sort engine.
package sort_pkg;

  typedef enum logic [1:0] {LOAD, FULL, SORT, DRAIN} state_t;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 8;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sort_compare_swap.sv
// Unsigned compare-swap: orders a pair, swap flags a strictly greater a.
module sort_compare_swap #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] hi,
  output logic              swap
);

  assign swap = (a > b);
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;

endmodule

// File: rtl/bubble_sort_engine.sv
// Load DEPTH words, bubble-sort them in place one compare-swap per clock,
// then stream them out smallest first over a valid/ready port.
module bubble_sort_engine
  import sort_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              start,
  output logic              busy,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              done
);

  localparam int IDX_W = idx_width(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] LAST_PASS = IDX_W'((DEPTH > 1) ? DEPTH - 2 : 0);

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  j;
  logic [IDX_W-1:0]  pass;
  logic              swapped;

  logic [IDX_W-1:0]  j_nxt;
  logic [IDX_W-1:0]  j_last;
  logic [DATA_W-1:0] lo;
  logic [DATA_W-1:0] hi;
  logic              swap;

  assign j_nxt  = j + 1'b1;
  assign j_last = LAST_PASS - pass;

  sort_compare_swap #(.DATA_W(DATA_W)) u_cmp (
    .a    (mem[j]),
    .b    (mem[j_nxt]),
    .lo   (lo),
    .hi   (hi),
    .swap (swap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      j         <= '0;
      pass      <= '0;
      swapped   <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        LOAD: begin
          if (in_valid) begin
            mem[wr_idx] <= in_data;
            if (wr_idx == LAST_IDX) begin
              state    <= FULL;
              in_ready <= 1'b0;
            end else begin
              wr_idx <= wr_idx + 1'b1;
            end
          end
        end
        FULL: begin
          if (start) begin
            pass    <= '0;
            j       <= '0;
            swapped <= 1'b0;
            if (DEPTH == 1) begin
              state     <= DRAIN;
              out_valid <= 1'b1;
              out_data  <= mem[0];
            end else begin
              state <= SORT;
              busy  <= 1'b1;
            end
          end
        end
        SORT: begin
          if (swap) begin
            mem[j]     <= lo;
            mem[j_nxt] <= hi;
          end
          if (j == j_last) begin
            if (!(swapped || swap) || pass == LAST_PASS) begin
              state     <= DRAIN;
              busy      <= 1'b0;
              out_valid <= 1'b1;
              // mem[0] may be rewritten by this very compare-swap
              out_data  <= (j == '0) ? lo : mem[0];
            end else begin
              pass    <= pass + 1'b1;
              j       <= '0;
              swapped <= 1'b0;
            end
          end else begin
            j       <= j_nxt;
            swapped <= swapped | swap;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (rd_idx == LAST_IDX) begin
              state     <= LOAD;
              out_valid <= 1'b0;
              done      <= 1'b1;
              wr_idx    <= '0;
              rd_idx    <= '0;
              in_ready  <= 1'b1;
            end else begin
              rd_idx   <= rd_idx + 1'b1;
              out_data <= mem[rd_idx + 1'b1];
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_bubble_sort_engine.sv
// Bench for bubble_sort_engine: directed and random jobs checked against a queue-sort reference.
module tb_bubble_sort_engine;

  typedef logic [7:0] vec_t [8];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic       start = 1'b0;
  logic       busy;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;
  logic       done;

  int tests_run = 0;
  int tests_failed = 0;

  bubble_sort_engine #(.DATA_W(8), .DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .start     (start),
    .busy      (busy),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Reference: ascending order via queue sort
  function automatic vec_t ref_sorted(input vec_t w);
    logic [7:0] q[$];
    vec_t r;
    for (int i = 0; i < 8; i++) q.push_back(w[i]);
    q.sort();
    for (int i = 0; i < 8; i++) r[i] = q[i];
    return r;
  endfunction

  // Reference: compares performed by bubble sort with early exit on a clean pass
  function automatic int ref_cycles(input vec_t w);
    vec_t a;
    int c;
    bit sw;
    logic [7:0] t;
    a = w;
    c = 0;
    for (int p = 0; p < 7; p++) begin
      sw = 0;
      for (int k = 0; k < 7 - p; k++) begin
        c++;
        if (a[k] > a[k+1]) begin
          t = a[k]; a[k] = a[k+1]; a[k+1] = t; sw = 1;
        end
      end
      if (!sw) break;
    end
    return c;
  endfunction

  task automatic load_n(input vec_t w, input int first, input int n);
    int cnt;
    for (int i = first; i < first + n; i++) begin
      in_valid = 1'b1;
      in_data  = w[i];
      cnt = 0;
      while (!in_ready && cnt < 50) begin
        @(negedge clk);
        cnt++;
      end
      tests_run++;
      if (in_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL load_ready word %0d: in_ready=%b required 1", i, in_ready);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic sort_and_count(input string name, input int exp_cycles);
    int cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (busy && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    tests_run++;
    if (cnt !== exp_cycles) begin
      tests_failed++;
      $display("FAIL %s busy_cycles: got %0d required %0d", name, cnt, exp_cycles);
    end
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,..., 2: random ready
  task automatic drain_check(input string name, input vec_t exp, input int mode);
    int idx;
    int k;
    bit rdy;
    idx = 0;
    k = 0;
    while (idx < 8 && k < 500) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (k % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== exp[idx]) begin
        tests_failed++;
        $display("FAIL %s drain[%0d]: valid=%b data=%0d required valid=1 data=%0d",
                 name, idx, out_valid, out_data, exp[idx]);
      end
      if (rdy) idx++;
      k++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    tests_run++;
    if (idx != 8 || done !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s done_cycle: idx=%0d done=%b out_valid=%b in_ready=%b busy=%b required 8,1,0,1,0",
               name, idx, done, out_valid, in_ready, busy);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s done_pulse_width: done=%b required 0", name, done);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    tests_run++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || out_data !== 8'd0) begin
      tests_failed++;
      $display("FAIL %s reset_outputs: in_ready=%b busy=%b out_valid=%b done=%b out_data=%0d required 1,0,0,0,0",
               name, in_ready, busy, out_valid, done, out_data);
    end
  endtask

  task automatic run_job(input string name, input vec_t w, input int mode);
    load_n(w, 0, 8);
    sort_and_count(name, ref_cycles(w));
    drain_check(name, ref_sorted(w), mode);
  endtask

  task automatic test_reset();
    vec_t w = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset_init");
    load_n(w, 0, 3);
    #2 rst = 1'b1;
    #1 check_reset_outputs("reset_midcycle");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reverse();
    vec_t w = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    vec_t e = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    load_n(w, 0, 8);
    sort_and_count("reverse", 28);
    drain_check("reverse", e, 0);
  endtask

  task automatic test_presorted();
    vec_t w = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    load_n(w, 0, 8);
    sort_and_count("presorted", 7);
    drain_check("presorted", w, 0);
  endtask

  task automatic test_extremes();
    vec_t w = '{8'd255, 8'd0, 8'd255, 8'd0, 8'd128, 8'd128, 8'd1, 8'd254};
    vec_t e = '{8'd0, 8'd0, 8'd1, 8'd128, 8'd128, 8'd254, 8'd255, 8'd255};
    load_n(w, 0, 8);
    sort_and_count("extremes", ref_cycles(w));
    drain_check("extremes", e, 0);
  endtask

  task automatic test_stall_drain();
    vec_t w;
    for (int i = 0; i < 8; i++) w[i] = 8'($urandom_range(0, 255));
    load_n(w, 0, 5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL start_in_load: busy=%b in_ready=%b required 0,1", busy, in_ready);
    end
    load_n(w, 5, 3);
    repeat (3) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_not_latched: busy=%b in_ready=%b out_valid=%b required 0,0,0",
               busy, in_ready, out_valid);
    end
    sort_and_count("stall", ref_cycles(w));
    drain_check("stall", ref_sorted(w), 1);
  endtask

  task automatic test_reset_mid_sort();
    vec_t w = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    vec_t v;
    load_n(w, 0, 8);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("reset_in_sort");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_in_sort_hold");
    v[0] = 8'd3; v[1] = 8'd1; v[2] = 8'd2;
    for (int i = 3; i < 8; i++) v[i] = 8'($urandom_range(0, 255));
    run_job("after_reset", v, 0);
  endtask

  task automatic test_back_to_back();
    vec_t w;
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 8; i++) w[i] = 8'($urandom_range(0, 15));
      run_job("random", w, 2);
    end
  endtask

  initial begin
    test_reset();
    test_reverse();
    test_presorted();
    test_extremes();
    test_stall_drain();
    test_reset_mid_sort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
